// File: rtl/vrased_pkg.sv
// vrased_pkg: SW-Att region constants, scheduler state encoding and abort codes
package vrased_pkg;
    localparam logic [15:0] SMEM_BASE      = 16'hA000;
    localparam logic [15:0] SMEM_SIZE      = 16'h4000;
    localparam logic [15:0] LAST_SMEM_ADDR = SMEM_BASE + SMEM_SIZE - 16'd2;
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ARM   = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_ABORT = 3'd4;
    localparam logic [1:0] AB_NONE   = 2'd0;
    localparam logic [1:0] AB_VIOL   = 2'd1;
    localparam logic [1:0] AB_ARM_TO = 2'd2;
    localparam logic [1:0] AB_RUN_TO = 2'd3;
endpackage

// File: rtl/swatt_rr_arb2.sv
// swatt_rr_arb2: two-way round-robin pick with a last-served register updated on a strobe
module swatt_rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    input  logic upd,
    input  logic served_b,
    output logic pick_b
);
    logic last_b_q, last_b_d;
    always_comb begin
        last_b_d = upd ? served_b : last_b_q;
        pick_b   = req_b && (!req_a || !last_b_q);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_b_q <= 1'b1;
        else     last_b_q <= last_b_d;
    end
endmodule

// File: rtl/swatt_req_scheduler.sv
// swatt_req_scheduler: arbitrates SW-Att runs between two requesters and polices entry, exit and timeouts
module swatt_req_scheduler
    import vrased_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int ARM_TIMEOUT = 256,
    parameter logic [CNT_W-1:0] RUN_MAX = 16'hFFF0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pc,
    input  logic        violation,
    input  logic        req_a,
    input  logic        req_b,
    output logic        gnt_a,
    output logic        gnt_b,
    output logic        busy,
    output logic        done_a,
    output logic        done_b,
    output logic        abort,
    output logic [1:0]  abort_code
);
    localparam logic [CNT_W-1:0] ARM_LAST = CNT_W'(ARM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] RUN_LAST = RUN_MAX - 1'b1;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             gnt_a_q, gnt_a_d, gnt_b_q, gnt_b_d;
    logic             done_a_q, done_a_d, done_b_q, done_b_d;
    logic             abort_q, abort_d;
    logic [1:0]       code_q, code_d;
    logic             prev_last_q;
    logic             in_smem, at_base, at_last;
    logic             fin, kill, upd, pick_b;
    logic [1:0]       kcode;
    assign in_smem = (pc >= SMEM_BASE) && (pc <= LAST_SMEM_ADDR);
    assign at_base = pc == SMEM_BASE;
    assign at_last = pc == LAST_SMEM_ADDR;
    swatt_rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .req_a    (req_a),
        .req_b    (req_b),
        .upd      (upd),
        .served_b (gnt_b_q),
        .pick_b   (pick_b)
    );
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        gnt_a_d  = gnt_a_q;
        gnt_b_d  = gnt_b_q;
        done_a_d = 1'b0;
        done_b_d = 1'b0;
        abort_d  = 1'b0;
        code_d   = code_q;
        fin      = 1'b0;
        kill     = 1'b0;
        kcode    = AB_NONE;
        upd      = 1'b0;
        case (state_q)
            ST_IDLE: if (!violation && (req_a || req_b)) begin
                state_d = ST_ARM;
                gnt_a_d = !pick_b;
                gnt_b_d = pick_b;
                cnt_d   = '0;
            end
            ST_ARM: begin
                if (violation || (in_smem && !at_base)) begin
                    kill  = 1'b1;
                    kcode = AB_VIOL;
                end else if (at_base) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else if (cnt_q == ARM_LAST) begin
                    kill  = 1'b1;
                    kcode = AB_ARM_TO;
                end else cnt_d = cnt_q + 1'b1;
            end
            ST_RUN: begin
                if (violation) begin
                    kill  = 1'b1;
                    kcode = AB_VIOL;
                end else if (!in_smem && prev_last_q) fin = 1'b1;
                else if (cnt_q == RUN_LAST) begin
                    kill  = 1'b1;
                    kcode = AB_RUN_TO;
                end else cnt_d = cnt_q + 1'b1;
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_ABORT: state_d = violation ? ST_ABORT : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (fin || kill) begin
            state_d  = fin ? ST_DONE : ST_ABORT;
            done_a_d = fin && gnt_a_q;
            done_b_d = fin && gnt_b_q;
            abort_d  = kill;
            code_d   = kill ? kcode : code_q;
            gnt_a_d  = 1'b0;
            gnt_b_d  = 1'b0;
            cnt_d    = '0;
            upd      = 1'b1;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            gnt_a_q     <= 1'b0;
            gnt_b_q     <= 1'b0;
            done_a_q    <= 1'b0;
            done_b_q    <= 1'b0;
            abort_q     <= 1'b0;
            code_q      <= AB_NONE;
            prev_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gnt_a_q     <= gnt_a_d;
            gnt_b_q     <= gnt_b_d;
            done_a_q    <= done_a_d;
            done_b_q    <= done_b_d;
            abort_q     <= abort_d;
            code_q      <= code_d;
            prev_last_q <= at_last;
        end
    end
    assign gnt_a      = gnt_a_q;
    assign gnt_b      = gnt_b_q;
    assign busy       = state_q != ST_IDLE;
    assign done_a     = done_a_q;
    assign done_b     = done_b_q;
    assign abort      = abort_q;
    assign abort_code = code_q;
endmodule
